dma_copy_engine: RTL

- Single-channel DMA copy engine that moves a block of 32-bit words from a source address to a destination address in the shared word RAM.
- Directly upstream of the RAM: sole driver of its cen/wen/addr/din; consumes its registered dout.
- A host programs source, destination, word count and start through a small register port.
- Engine runs read/write word pairs, then raises done and an optional interrupt.

---
 rtl/dma_copy_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - single-channel word copy engine driving a shared word RAM
// Host programs SRC/DST/SIZE then starts; engine alternates RD/WR cycles per word.
module dma_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [2:0]        s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              m_cen,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_SIZE   = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0]   size_q, size_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               ie_q, ie_d;
  logic               done_q, done_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  din_q;

  logic busy;
  logic host_wr;
  logic start;
  logic unused_din;

  assign busy    = (state_q != ST_IDLE);
  assign host_wr = s_sel && s_wr;
  assign start   = host_wr && (s_addr == REG_CTRL) && s_din[0] && !busy;

  // Upper host data bits have no destination in any register.
  assign unused_din = ^{1'b0, s_din[DATA_W-1:ADDR_W]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    size_d  = size_q;
    idx_d   = idx_q;
    ie_d    = ie_q;
    done_d  = done_q;

    if (host_wr && !busy) begin
      case (s_addr)
        REG_SRC:  src_d  = s_din[ADDR_W-1:0];
        REG_DST:  dst_d  = s_din[ADDR_W-1:0];
        REG_SIZE: size_d = s_din[LEN_W-1:0];
        default:  ;
      endcase
    end
    if (host_wr && (s_addr == REG_CTRL)) begin
      ie_d = s_din[1];
    end
    if (host_wr && (s_addr == REG_STATUS) && s_din[1]) begin
      done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          idx_d   = '0;
          state_d = (size_q != '0) ? ST_RD : ST_DONE;
        end
      end
      ST_RD: begin
        state_d = ST_WR;
      end
      ST_WR: begin
        if (idx_q == size_q - LEN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = ST_RD;
        end
      end
      ST_DONE: begin
        // Setting done takes priority over a same-cycle host clear.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM side: write data is the registered read word arriving this cycle.
  always_comb begin
    m_cen  = 1'b0;
    m_wen  = 1'b0;
    m_addr = addr_q;
    m_din  = din_q;
    case (state_q)
      ST_RD: begin
        m_cen  = 1'b1;
        m_addr = src_q + ADDR_W'(idx_q);
      end
      ST_WR: begin
        m_cen  = 1'b1;
        m_wen  = 1'b1;
        m_addr = dst_q + ADDR_W'(idx_q);
        m_din  = m_dout;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      case (s_addr)
        REG_SRC:    s_dout = DATA_W'(src_q);
        REG_DST:    s_dout = DATA_W'(dst_q);
        REG_SIZE:   s_dout = DATA_W'(size_q);
        REG_CTRL:   s_dout = DATA_W'({ie_q, 1'b0});
        REG_STATUS: s_dout = DATA_W'({done_q, busy});
        default:    s_dout = '0;
      endcase
    end
  end

  assign irq = done_q && ie_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      addr_q  <= m_addr;
      din_q   <= m_din;
    end
  end

endmodule
